data_memory_responder: RTL and testbench
========================================

Name: data_memory_responder

Overview:
Memory-side responder for the data cache's RAM interface. It accepts word writes (write-through traffic) and line-fill reads from the cache, and holds a word-addressed backing array. Reads return an aligned 128-bit line after a fixed, parameterised latency. It sits between the data cache and the top-level datapath in place of an ideal RAM, so miss/fill timing is modelled cycle-accurately.

Parameters:
ADDR_BITS, 10, word-address width; array holds 2^ADDR_BITS 32-bit words (must be >= 2)
READ_LATENCY, 4, cycles from read acceptance to oready pulse (>= 1)
WRITE_LATENCY, 2, cycles from write acceptance to commit and oready pulse (>= 1)

Ports:
clk  input  1  clock; all state changes on posedge
rst  input  1  synchronous reset, active-high
iaddr  input  32  byte address of request
idata_write  input  32  write data
iSigMemRead  input  1  line-read request (level)
iSigMemWrite  input  1  word-write request (level)
omem_line  output  128  returned line; word0 in [31:0] .. word3 in [127:96]
oready  output  1  one-cycle completion pulse for the current transaction
obusy  output  1  high while a transaction is outstanding (any state but IDLE)

Behaviour:
- Reset (rst high at posedge): state=IDLE, omem_line=0, oready=0, obusy=0, latency counter=0, pending-read flag=0. Array contents are not touched by reset. Reset mid-transaction aborts it: no commit, no oready.
- Word index = iaddr[ADDR_BITS+1:2]; upper address bits are ignored, so addresses wrap modulo array size. iaddr[1:0] are ignored.
- Line base = word index with the low 2 bits cleared. omem_line[32k+31:32k] = array[base+k] for k=0..3.
- FSM states: IDLE, WRITE_WAIT, READ_WAIT, DONE.
- IDLE: requests are sampled only here.
  - iSigMemWrite high: latch address and data, counter=WRITE_LATENCY-1, go to WRITE_WAIT.
  - If iSigMemRead is also high in the same cycle, set the pending-read flag and latch the read address. The write is serviced first.
  - Else, if iSigMemRead is high: latch address, counter=READ_LATENCY-1, go to READ_WAIT.
  - Else stay in IDLE.
- WRITE_WAIT / READ_WAIT: decrement the counter each cycle. At counter==0 take the exit edge.
  - Write exit edge: commit array[idx]=data.
  - Read exit edge: load omem_line from the array, reflecting all previously committed writes.
  - Then go to DONE.
- DONE: oready=1 for exactly this cycle.
  - If the pending-read flag is set: clear it, load counter=READ_LATENCY-1, go to READ_WAIT. oready is not reasserted before that read completes.
  - Otherwise go to IDLE.
- Timing: with the request accepted at edge N, oready is high during the cycle following edge N+LATENCY. A back-to-back request held level is re-accepted at the first IDLE edge after DONE.
- omem_line holds its value until the next read completes. Writes never alter omem_line, even when they hit the same line.
- Requests arriving while obusy=1 are ignored, not queued. The only exception is the pending read captured alongside a write.
- obusy = (state != IDLE), registered.

Test Plan:
- Reset, then write 0xDEADBEEF to 0x0000_0010 (LATENCY=2) -> oready pulses once, 2 cycles after acceptance; obusy high for 3 cycles.
- Write 0x11,0x22,0x33,0x44 to 0x40,0x44,0x48,0x4C; then read 0x48 -> oready pulses 4 cycles after acceptance; omem_line = 0x00000044_00000033_00000022_00000011.
- Assert read and write together (addr 0x40, data 0xAAAA5555) -> write completes first, then read; second oready shows omem_line[31:0]=0xAAAA5555.
- Write 0x77 to 0x1000 with ADDR_BITS=10 -> a read of 0x0000 returns word0=0x77 (wrap).
- Assert rst in READ_WAIT after a write-then-read setup -> no oready, obusy=0 next cycle; a following read of the same line returns the previously committed data unchanged.
- Pulse iSigMemWrite while obusy=1 -> ignored; array word unchanged when read back.

Source files
------------

// File: rtl/data_memory_responder.sv
// Memory-side responder for the data cache RAM port.
// Word-addressed backing array; word writes commit after WRITE_LATENCY cycles,
// line reads return an aligned 4-word line after READ_LATENCY cycles.
// One transaction at a time; a read asserted together with a write is held
// as a pending read and serviced right after the write completes.
module data_memory_responder #(
  parameter int ADDR_BITS     = 10,
  parameter int READ_LATENCY  = 4,
  parameter int WRITE_LATENCY = 2
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [31:0]  iaddr,
  input  logic [31:0]  idata_write,
  input  logic         iSigMemRead,
  input  logic         iSigMemWrite,
  output logic [127:0] omem_line,
  output logic         oready,
  output logic         obusy
);

  localparam int MAX_LAT = (READ_LATENCY > WRITE_LATENCY) ? READ_LATENCY : WRITE_LATENCY;
  localparam int CW      = (MAX_LAT > 1) ? $clog2(MAX_LAT) : 1;
  localparam logic [CW-1:0] RD_LOAD = CW'(READ_LATENCY - 1);
  localparam logic [CW-1:0] WR_LOAD = CW'(WRITE_LATENCY - 1);

  typedef enum logic [1:0] {IDLE, WRITE_WAIT, READ_WAIT, DONE} state_t;

  state_t                 state;
  logic [CW-1:0]          cnt;
  logic                   pend_rd;
  logic [ADDR_BITS-1:0]   wr_idx;
  logic [ADDR_BITS-1:0]   rd_idx;
  logic [31:0]            wr_data;
  logic [31:0]            mem [2**ADDR_BITS];

  logic [ADDR_BITS-1:0]   req_idx;
  logic [ADDR_BITS-1:0]   line_base;
  logic [127:0]           rd_line;
  logic                   wr_commit;
  logic                   unused_addr;

  // Upper address bits and byte offset are don't-care: the array wraps.
  assign req_idx     = iaddr[ADDR_BITS+1:2];
  assign unused_addr = ^{iaddr[31:ADDR_BITS+2], iaddr[1:0]};

  assign line_base = {rd_idx[ADDR_BITS-1:2], 2'b00};
  assign rd_line   = {mem[line_base | ADDR_BITS'(3)], mem[line_base | ADDR_BITS'(2)],
                      mem[line_base | ADDR_BITS'(1)], mem[line_base]};

  assign wr_commit = (state == WRITE_WAIT) && (cnt == '0);

  // Backing array: written only on the write exit edge; reset leaves it alone.
  always_ff @(posedge clk) begin
    if (!rst && wr_commit) mem[wr_idx] <= wr_data;
  end

  // Transaction FSM with registered oready/obusy and the returned line.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      omem_line <= '0;
      oready    <= 1'b0;
      obusy     <= 1'b0;
      cnt       <= '0;
      pend_rd   <= 1'b0;
    end else begin
      oready <= 1'b0;
      case (state)
        IDLE: begin
          if (iSigMemWrite) begin
            wr_idx  <= req_idx;
            wr_data <= idata_write;
            cnt     <= WR_LOAD;
            state   <= WRITE_WAIT;
            obusy   <= 1'b1;
            if (iSigMemRead) begin
              pend_rd <= 1'b1;
              rd_idx  <= req_idx;
            end
          end else if (iSigMemRead) begin
            rd_idx <= req_idx;
            cnt    <= RD_LOAD;
            state  <= READ_WAIT;
            obusy  <= 1'b1;
          end
        end
        WRITE_WAIT: begin
          if (cnt == '0) begin
            state  <= DONE;
            oready <= 1'b1;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        READ_WAIT: begin
          if (cnt == '0) begin
            omem_line <= rd_line;
            state     <= DONE;
            oready    <= 1'b1;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        DONE: begin
          if (pend_rd) begin
            pend_rd <= 1'b0;
            cnt     <= RD_LOAD;
            state   <= READ_WAIT;
          end else begin
            state <= IDLE;
            obusy <= 1'b0;
          end
        end
        default: begin
          state <= IDLE;
          obusy <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_data_memory_responder.sv
// Bench for data_memory_responder: transaction-level reference model
// (scheduled completion edges + plain array) checked every cycle, plus
// directed scenarios with hand-computed expectations.
module tb_data_memory_responder;

  localparam int AB = 10;
  localparam int RL = 4;
  localparam int WL = 2;

  logic         clk = 1'b0;
  logic         rst;
  logic [31:0]  iaddr, idata_write;
  logic         rd, wr;
  logic [127:0] omem_line;
  logic         oready, obusy;

  always #5 clk = ~clk;

  data_memory_responder #(.ADDR_BITS(AB), .READ_LATENCY(RL), .WRITE_LATENCY(WL)) dut (
    .clk(clk), .rst(rst), .iaddr(iaddr), .idata_write(idata_write),
    .iSigMemRead(rd), .iSigMemWrite(wr),
    .omem_line(omem_line), .oready(oready), .obusy(obusy)
  );

  int n_cmp  = 0;
  int n_fail = 0;

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h want %h at %0t", nm, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  logic [31:0]  m_mem [2**AB];
  int           edge_n  = 0;
  int           m_free  = 0;
  int           w_edge  = -1, r_edge = -1;
  int           w_idx, r_idx;
  logic [31:0]  w_data;
  bit           started = 0;
  bit           exp_ready, exp_busy;
  logic [127:0] exp_line;

  initial for (int i = 0; i < 2**AB; i++) m_mem[i] = '0;

  // Each posedge: retire whatever is scheduled for this edge, then accept a
  // new request if the responder is free; busy lasts through the last DONE.
  always @(posedge clk) begin
    int idx, base, fin;
    edge_n++;
    if (rst) begin
      w_edge = -1; r_edge = -1; m_free = edge_n + 1;
      exp_ready = 0; exp_busy = 0; exp_line = '0; started = 1;
    end else begin
      exp_ready = 0;
      if (edge_n == w_edge) begin
        m_mem[w_idx] = w_data; exp_ready = 1; w_edge = -1;
      end
      if (edge_n == r_edge) begin
        base = r_idx & ~3;
        exp_line = {m_mem[base+3], m_mem[base+2], m_mem[base+1], m_mem[base]};
        exp_ready = 1; r_edge = -1;
      end
      if (edge_n >= m_free && (wr || rd)) begin
        idx = int'(iaddr[AB+1:2]);
        if (wr) begin
          w_edge = edge_n + WL; w_idx = idx; w_data = idata_write; fin = w_edge;
          if (rd) begin
            r_edge = edge_n + WL + 1 + RL; r_idx = idx; fin = r_edge;
          end
        end else begin
          r_edge = edge_n + RL; r_idx = idx; fin = r_edge;
        end
        m_free = fin + 2;
      end
      exp_busy = (edge_n < m_free - 1);
    end
  end

  // Per-cycle comparison against the model.
  always @(negedge clk) begin
    if (started) begin
      chk("oready", {127'b0, oready}, {127'b0, exp_ready});
      chk("obusy", {127'b0, obusy}, {127'b0, exp_busy});
      chk("omem_line", omem_line, exp_line);
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic idle_wait();
    int k = 0;
    while (obusy && k < 100) begin
      @(posedge clk); #1; k++;
    end
    if (k >= 100) chk("idle_timeout", {127'b0, obusy}, 128'd0);
  endtask

  task automatic req(input bit r, input bit w, input logic [31:0] a, input logic [31:0] d);
    idle_wait();
    rd = r; wr = w; iaddr = a; idata_write = d;
    @(posedge clk); #1;
    rd = 0; wr = 0;
  endtask

  task automatic wait_ready(output int cyc);
    cyc = 0;
    do begin
      @(negedge clk); cyc++;
    end while (!oready && cyc < 60);
    if (!oready) chk("ready_timeout", {127'b0, oready}, 128'd1);
  endtask

  initial begin
    int c, c2, busy_cnt, rdy_cnt, rdy_pos;
    rst = 1; rd = 0; wr = 0; iaddr = '0; idata_write = '0;
    repeat (2) @(posedge clk);
    #1 rst = 0;
    chk("reset_line", omem_line, 128'd0);
    chk("reset_busy", {127'b0, obusy}, 128'd0);
    chk("reset_ready", {127'b0, oready}, 128'd0);

    // Fill the array so every read has defined contents.
    for (int i = 0; i < 2**AB; i++) req(0, 1, 32'(i) << 2, 32'hC0DE0000 | 32'(i));

    // Single write: busy 3 cycles, one oready at latency 2.
    req(0, 1, 32'h0000_0010, 32'hDEADBEEF);
    busy_cnt = 0; rdy_cnt = 0; rdy_pos = 0;
    for (int i = 1; i <= 6; i++) begin
      @(negedge clk);
      if (obusy) busy_cnt++;
      if (oready) begin rdy_cnt++; rdy_pos = i; end
    end
    chk("t1_busy_cycles", 128'(busy_cnt), 128'd3);
    chk("t1_ready_count", 128'(rdy_cnt), 128'd1);
    chk("t1_ready_pos", 128'(rdy_pos), 128'd3);

    // Four writes then a line read.
    req(0, 1, 32'h40, 32'h11); req(0, 1, 32'h44, 32'h22);
    req(0, 1, 32'h48, 32'h33); req(0, 1, 32'h4C, 32'h44);
    req(1, 0, 32'h48, 32'h0);
    wait_ready(c);
    chk("t2_read_latency", 128'(c), 128'(RL + 1));
    chk("t2_line", omem_line, 128'h00000044_00000033_00000022_00000011);

    // Read and write together: write first, then the pending read.
    req(1, 1, 32'h40, 32'hAAAA5555);
    wait_ready(c);
    chk("t3_write_latency", 128'(c), 128'(WL + 1));
    chk("t3_line_unchanged_by_write", omem_line, 128'h00000044_00000033_00000022_00000011);
    wait_ready(c2);
    chk("t3_read_gap", 128'(c2), 128'(RL + 1));
    chk("t3_word0", {96'b0, omem_line[31:0]}, 128'hAAAA5555);
    chk("t3_word1", {96'b0, omem_line[63:32]}, 128'h22);

    // Address wrap: 0x1000 aliases word 0.
    req(0, 1, 32'h0000_1000, 32'h77);
    req(1, 0, 32'h0000_0000, 32'h0);
    wait_ready(c);
    chk("t4_wrap_word0", {96'b0, omem_line[31:0]}, 128'h77);
    chk("t4_wrap_word1", {96'b0, omem_line[63:32]}, 128'hC0DE0001);

    // Reset in READ_WAIT aborts the read.
    req(0, 1, 32'h80, 32'h1234);
    req(1, 0, 32'h84, 32'h0);
    repeat (2) @(posedge clk);
    #1 rst = 1;
    @(posedge clk); #1 rst = 0;
    chk("t5_busy_after_rst", {127'b0, obusy}, 128'd0);
    chk("t5_ready_after_rst", {127'b0, oready}, 128'd0);
    chk("t5_line_after_rst", omem_line, 128'd0);
    req(1, 0, 32'h84, 32'h0);
    wait_ready(c);
    chk("t5_word0", {96'b0, omem_line[31:0]}, 128'h1234);

    // Write pulsed while busy is dropped.
    req(1, 0, 32'h40, 32'h0);
    wr = 1; iaddr = 32'h40; idata_write = 32'h99;
    @(posedge clk); #1 wr = 0;
    wait_ready(c);
    req(1, 0, 32'h40, 32'h0);
    wait_ready(c);
    chk("t6_ignored_write", {96'b0, omem_line[31:0]}, 128'hAAAA5555);

    // Randomized traffic, including requests while busy and stray resets.
    for (int i = 0; i < 3000; i++) begin
      @(posedge clk); #1;
      rst         = ($urandom_range(99) == 0);
      rd          = ($urandom_range(3) == 0);
      wr          = ($urandom_range(3) == 0);
      iaddr       = $urandom & 32'hFFFF_F03F;
      idata_write = $urandom;
    end
    @(posedge clk); #1;
    rst = 0; rd = 0; wr = 0;
    repeat (20) @(posedge clk);
    @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
